ula_exec_seq: RTL and testbench

//  Execution unit that consumes the 4-bit ALU operation code produced by ALU control.

---
 rtl/ula_exec_seq.sv | 189 ++++++++++++++++++
 tb/tb_ula_exec_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ula_exec_seq.sv
// EX-stage execution unit: single-cycle add/sub/logic/slt, plus iterative
// unsigned shift-add multiply and restoring divide/modulo behind a start/done handshake.
module ula_exec_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_zero,
    output logic             busy,
    output logic             ready,
    output logic             done
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MULT = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_MOD  = 4'd8;

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand (mult) or divisor (div/mod)
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             div_zero_q, div_zero_d;

    // One shift-add step: {hi,lo} holds partial product above the unconsumed multiplier bits.
    logic [WIDTH:0]   mul_acc;
    logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;
    // One restoring-divide step: hi is the partial remainder, lo shifts dividend out / quotient in.
    logic [WIDTH:0]   div_shift, div_trial;
    logic [WIDTH-1:0] div_hi_nxt, div_lo_nxt;

    always_comb begin
        mul_acc    = work_lo_q[0] ? ({1'b0, work_hi_q} + {1'b0, opnd_q}) : {1'b0, work_hi_q};
        mul_hi_nxt = mul_acc[WIDTH:1];
        mul_lo_nxt = {mul_acc[0], work_lo_q[WIDTH-1:1]};

        div_shift  = {work_hi_q, work_lo_q[WIDTH-1]};
        div_trial  = div_shift - {1'b0, opnd_q};
        if (!div_trial[WIDTH]) begin
            div_hi_nxt = div_trial[WIDTH-1:0];
            div_lo_nxt = {work_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            div_hi_nxt = div_shift[WIDTH-1:0];
            div_lo_nxt = {work_lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        opnd_d      = opnd_q;
        work_hi_d   = work_hi_q;
        work_lo_d   = work_lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d     = S_DONE;
                    result_hi_d = '0;
                    div_zero_d  = 1'b0;
                    case (op)
                        OP_ADD:  result_d = a + b;
                        OP_SUB:  result_d = a - b;
                        OP_AND:  result_d = a & b;
                        OP_OR:   result_d = a | b;
                        OP_XOR:  result_d = a ^ b;
                        OP_SLT:  result_d = WIDTH'($signed(a) < $signed(b));
                        OP_MULT: begin
                            state_d   = S_CALC;
                            result_d  = result_q;
                            result_hi_d = result_hi_q;
                            div_zero_d  = div_zero_q;
                            op_d      = op;
                            opnd_d    = a;
                            work_hi_d = '0;
                            work_lo_d = b;
                            cnt_d     = CNT_INIT;
                        end
                        OP_DIV, OP_MOD: begin
                            if (b == '0) begin
                                div_zero_d  = 1'b1;
                                result_d    = (op == OP_DIV) ? '1 : a;
                                result_hi_d = a;
                            end else begin
                                state_d     = S_CALC;
                                result_d    = result_q;
                                result_hi_d = result_hi_q;
                                div_zero_d  = div_zero_q;
                                op_d        = op;
                                opnd_d      = b;
                                work_hi_d   = '0;
                                work_lo_d   = a;
                                cnt_d       = CNT_INIT;
                            end
                        end
                        default: result_d = '0;
                    endcase
                    if (state_d == S_DONE) begin
                        zero_d = (result_d == '0);
                    end
                end
            end

            S_CALC: begin
                if (op_q == OP_MULT) begin
                    work_hi_d = mul_hi_nxt;
                    work_lo_d = mul_lo_nxt;
                end else begin
                    work_hi_d = div_hi_nxt;
                    work_lo_d = div_lo_nxt;
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = S_DONE;
                    result_d    = (op_q == OP_MOD) ? work_hi_d : work_lo_d;
                    result_hi_d = work_hi_d;
                    zero_d      = (result_d == '0);
                    div_zero_d  = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            opnd_q      <= '0;
            work_hi_q   <= '0;
            work_lo_q   <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            opnd_q      <= opnd_d;
            work_hi_q   <= work_hi_d;
            work_lo_q   <= work_lo_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign div_zero  = div_zero_q;
    assign busy      = (state_q == S_CALC);
    assign ready     = (state_q == S_IDLE) || (state_q == S_DONE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_ula_exec_seq.sv
// Directed-vector bench for ula_exec_seq at WIDTH=32; expected values are hand-computed constants.
module tb_ula_exec_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] result, result_hi;
    logic        zero, div_zero, busy, ready, done;

    int total = 0;
    int bad   = 0;

    ula_exec_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .div_zero  (div_zero),
        .busy      (busy),
        .ready     (ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Launches one op at a negedge, then samples each following negedge until done.
    // lat = posedges from the accepting edge to done; busy_n = cycles seen busy with ready low.
    // With poke set, a stray start (add) is driven mid-CALC and must be ignored.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit poke, output int lat, output int busy_n);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        lat = 0; busy_n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy && !ready) busy_n++;
            if (poke && lat == 5) begin
                start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
            end
        end while (!done && lat < 100);
        if (lat >= 100) check("done_timeout", 64'(done), 64'd1);
    endtask

    int lat, bsy, seen;

    initial begin
        reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_result",   64'(result),    64'd0);
        check("rst_result_hi",64'(result_hi), 64'd0);
        check("rst_flags",    64'({zero, div_zero, busy, ready, done}), 64'b00010);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(4'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, lat, bsy);
        check("add_lat",    64'(lat),    64'd1);
        check("add_result", 64'(result), 64'h8000_0000);
        check("add_zero",   64'(zero),   64'd0);

        run_op(4'd7, 32'hFFFF_FFFF, 32'h1, 1'b0, lat, bsy);
        check("slt_result", 64'(result), 64'd1);
        run_op(4'd7, 32'h1, 32'hFFFF_FFFF, 1'b0, lat, bsy);
        check("slt_false",  64'(result), 64'd0);

        run_op(4'd1, 32'h5, 32'h5, 1'b0, lat, bsy);
        check("sub_result", 64'(result), 64'd0);
        check("sub_zero",   64'(zero),   64'd1);

        run_op(4'd6, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, lat, bsy);
        check("xor_result", 64'(result), 64'hFF00_EDCB);
        run_op(4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, lat, bsy);
        check("and_result", 64'(result), 64'h00F0_1234);
        run_op(4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, lat, bsy);
        check("or_result",  64'(result), 64'hFFF0_FFFF);

        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bsy);
        check("mult_lat",  64'(lat), 64'd33);
        check("mult_busy", 64'(bsy), 64'd32);
        check("mult_prod", {result_hi, result}, 64'hFFFF_FFFE_0000_0001);
        run_op(4'd2, 32'h0001_2345, 32'h0000_1000, 1'b0, lat, bsy);
        check("mult_prod2", {result_hi, result}, 64'h0000_0000_1234_5000);

        run_op(4'd3, 32'h100, 32'h7, 1'b1, lat, bsy);
        check("div_lat", 64'(lat), 64'd33);
        check("div_qr",  {result_hi, result}, {32'h4, 32'h24});
        run_op(4'd8, 32'h100, 32'h7, 1'b0, lat, bsy);
        check("mod_lat", 64'(lat), 64'd33);
        check("mod_rr",  {result_hi, result}, {32'h4, 32'h4});
        run_op(4'd3, 32'hFFFF_FFFF, 32'h1_0000, 1'b0, lat, bsy);
        check("div_big", {result_hi, result}, {32'hFFFF, 32'hFFFF});

        run_op(4'd3, 32'h9, 32'h0, 1'b0, lat, bsy);
        check("dz_lat",  64'(lat), 64'd1);
        check("dz_flag", 64'(div_zero), 64'd1);
        check("dz_div",  {result_hi, result}, {32'h9, 32'hFFFF_FFFF});
        run_op(4'd8, 32'h9, 32'h0, 1'b0, lat, bsy);
        check("dz_mod",  {result_hi, result}, {32'h9, 32'h9});
        run_op(4'd0, 32'h1, 32'h2, 1'b0, lat, bsy);
        check("dz_clear", 64'({div_zero, result_hi}), 64'd0);
        check("add_small", 64'(result), 64'd3);

        repeat (3) @(negedge clk);
        check("hold_result", 64'(result), 64'd3);
        check("hold_idle",   64'({done, ready, busy}), 64'b010);

        run_op(4'd9, 32'h5, 32'h6, 1'b0, lat, bsy);
        check("illegal_res",  {result_hi, result}, 64'd0);
        check("illegal_zero", 64'(zero), 64'd1);

        // Abort a mult mid-CALC with an asynchronous reset.
        run_op(4'd0, 32'h10, 32'h1, 1'b0, lat, bsy);
        @(negedge clk);
        start = 1'b1; op = 4'd2; a = 32'hFFFF_FFFF; b = 32'h3;
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort_busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_res",   {result_hi, result}, 64'd0);
        check("abort_flags", 64'({zero, div_zero, busy, ready, done}), 64'b00010);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_nodone", 64'(seen), 64'd0);

        // Back-to-back: start held through DONE launches the next op.
        @(negedge clk);
        start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd2;
        @(negedge clk);
        check("b2b_first", 64'({done, result}), {31'd0, 1'b1, 32'd3});
        op = 4'd1; a = 32'd30; b = 32'd10;
        @(negedge clk);
        start = 1'b0;
        check("b2b_second", 64'({done, result}), {31'd0, 1'b1, 32'd20});
        @(negedge clk);
        check("b2b_end", 64'({done, ready}), 64'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
